// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave: register map, bit positions,
// frame length encoding and FSM states.
package spi_slave_pkg;

  // Register word offsets (paddr[3:2])
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_TXDATA = 2'd1;
  localparam logic [1:0] ADDR_RXDATA = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_LEN_LO = 1;
  localparam int CTRL_LEN_HI = 2;
  localparam int CTRL_RXIE   = 3;
  localparam int CTRL_ERRIE  = 4;

  // STATUS bit positions
  localparam int ST_RXV  = 0;
  localparam int ST_TXF  = 1;
  localparam int ST_OVR  = 2;
  localparam int ST_UDR  = 3;
  localparam int ST_BUSY = 4;

  // Frame length encoding
  typedef enum logic [1:0] {
    LEN_8   = 2'b00,
    LEN_16  = 2'b01,
    LEN_32  = 2'b10,
    LEN_32B = 2'b11
  } len_e;

  // Frame FSM
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Number of bits in a frame for a given length code
  function automatic logic [5:0] len_bits(input logic [1:0] len);
    case (len)
      LEN_8:   len_bits = 6'd8;
      LEN_16:  len_bits = 6'd16;
      default: len_bits = 6'd32;
    endcase
  endfunction

  // Left-align the transmit word so the frame MSB sits at bit 31
  function automatic logic [31:0] align_tx(input logic [31:0] d, input logic [1:0] len);
    case (len)
      LEN_8:   align_tx = {d[7:0], 24'd0};
      LEN_16:  align_tx = {d[15:0], 16'd0};
      default: align_tx = d;
    endcase
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Two-flop synchronizer with rising/falling edge detection on the
// synchronized level. IDLE_VAL sets the reset level of every flop so no
// spurious edge is reported after reset.
module spi_slave_sync #(
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= IDLE_VAL;
      sync_q <= IDLE_VAL;
      prev_q <= IDLE_VAL;
    end else begin
      meta_q <= d_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q    = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave.sv
// APB-programmable SPI slave, mode 0, MSB first, 8/16/32-bit frames.
// SPI inputs are synchronized into sys_clk and sampled on detected edges.
module spi_slave
  import spi_slave_pkg::*;
(
  input  logic        sys_clk,
  input  logic        rst_b,
  input  logic [31:0] apb_spis_paddr,
  input  logic        apb_spis_psel,
  input  logic        apb_spis_penable,
  input  logic        apb_spis_pwrite,
  input  logic [31:0] apb_spis_pwdata,
  output logic [31:0] spis_apb_prdata,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        ss_b,
  output logic        miso,
  output logic        miso_oe,
  output logic        spis_irq
);

  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_meta_q, mosi_s_q;

  logic [4:0]  ctrl_q,    ctrl_d;
  logic [31:0] tx_hold_q, tx_hold_d;
  logic        tx_full_q, tx_full_d;
  logic [31:0] rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        ovr_q,     ovr_d;
  logic        udr_q,     udr_d;
  state_e      state_q,   state_d;
  logic [31:0] tx_sh_q,   tx_sh_d;
  logic [31:0] rx_sh_q,   rx_sh_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  len_q,     len_d;

  logic       wr_acc, rd_acc, rd_rx;
  logic [1:0] addr;
  logic       unused_sig;

  spi_slave_sync #(.IDLE_VAL(1'b0)) u_sync_sclk (
    .clk   (sys_clk),
    .rst_n (rst_b),
    .d_in  (sclk),
    .q     (sclk_s),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_slave_sync #(.IDLE_VAL(1'b1)) u_sync_ss (
    .clk   (sys_clk),
    .rst_n (rst_b),
    .d_in  (ss_b),
    .q     (ss_s),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  // mosi only needs its level, aligned in latency with the sclk synchronizer
  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) begin
      mosi_meta_q <= 1'b0;
      mosi_s_q    <= 1'b0;
    end else begin
      mosi_meta_q <= mosi;
      mosi_s_q    <= mosi_meta_q;
    end
  end

  assign addr       = apb_spis_paddr[3:2];
  assign wr_acc     = apb_spis_psel & apb_spis_penable & apb_spis_pwrite;
  assign rd_acc     = apb_spis_psel & apb_spis_penable & ~apb_spis_pwrite;
  assign rd_rx      = rd_acc & (addr == ADDR_RXDATA);
  assign unused_sig = ^{apb_spis_paddr[31:4], apb_spis_paddr[1:0], sclk_s};

  // Next-state for registers, flags and the frame FSM; DONE beats a same-cycle RXDATA read
  always_comb begin
    ctrl_d     = ctrl_q;
    tx_hold_d  = tx_hold_q;
    tx_full_d  = tx_full_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    ovr_d      = ovr_q;
    udr_d      = udr_q;
    state_d    = state_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    bit_cnt_d  = bit_cnt_q;
    len_d      = len_q;

    if (wr_acc && addr == ADDR_CTRL)
      ctrl_d = apb_spis_pwdata[4:0];
    if (rd_rx)
      rx_valid_d = 1'b0;
    if (wr_acc && addr == ADDR_STATUS) begin
      if (apb_spis_pwdata[ST_OVR]) ovr_d = 1'b0;
      if (apb_spis_pwdata[ST_UDR]) udr_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (ctrl_q[CTRL_EN] && ss_fall) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = 6'd0;
          rx_sh_d   = 32'd0;
          len_d     = ctrl_q[CTRL_LEN_HI:CTRL_LEN_LO];
          if (tx_full_q) begin
            tx_sh_d   = align_tx(tx_hold_q, ctrl_q[CTRL_LEN_HI:CTRL_LEN_LO]);
            tx_full_d = 1'b0;
          end else begin
            tx_sh_d = 32'd0;
            udr_d   = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (ss_rise) begin
          state_d = ST_IDLE;
        end else begin
          if (sclk_rise) begin
            rx_sh_d   = {rx_sh_q[30:0], mosi_s_q};
            bit_cnt_d = bit_cnt_q + 6'd1;
            if (bit_cnt_q + 6'd1 == len_bits(len_q))
              state_d = ST_DONE;
          end
          if (sclk_fall)
            tx_sh_d = {tx_sh_q[30:0], 1'b0};
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (rx_valid_q && !rd_rx) begin
          ovr_d = 1'b1;
        end else begin
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_acc && addr == ADDR_TXDATA) begin
      tx_hold_d = apb_spis_pwdata;
      tx_full_d = 1'b1;
    end
  end

  // State registers, all cleared asynchronously
  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) begin
      ctrl_q     <= 5'd0;
      tx_hold_q  <= 32'd0;
      tx_full_q  <= 1'b0;
      rx_data_q  <= 32'd0;
      rx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
      udr_q      <= 1'b0;
      state_q    <= ST_IDLE;
      tx_sh_q    <= 32'd0;
      rx_sh_q    <= 32'd0;
      bit_cnt_q  <= 6'd0;
      len_q      <= 2'd0;
    end else begin
      ctrl_q     <= ctrl_d;
      tx_hold_q  <= tx_hold_d;
      tx_full_q  <= tx_full_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ovr_q      <= ovr_d;
      udr_q      <= udr_d;
      state_q    <= state_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      bit_cnt_q  <= bit_cnt_d;
      len_q      <= len_d;
    end
  end

  // APB read mux; TXDATA is write-only and reads as zero
  always_comb begin
    spis_apb_prdata = 32'd0;
    if (apb_spis_psel) begin
      case (addr)
        ADDR_CTRL:   spis_apb_prdata = {27'd0, ctrl_q};
        ADDR_RXDATA: spis_apb_prdata = rx_data_q;
        ADDR_STATUS: spis_apb_prdata = {27'd0, (state_q != ST_IDLE), udr_q, ovr_q,
                                        tx_full_q, rx_valid_q};
        default:     spis_apb_prdata = 32'd0;
      endcase
    end
  end

  assign miso     = ~ss_s & tx_sh_q[31];
  assign miso_oe  = ~ss_s;
  assign spis_irq = (rx_valid_q & ctrl_q[CTRL_RXIE]) |
                    ((ovr_q | udr_q) & ctrl_q[CTRL_ERRIE]);

endmodule
